// File: rtl/music_pkg.sv
// Shared types and constants for the note-playback controller.
//   ctrl_state_t  : controller FSM states
//   MEM_DEPTH     : note memory entries
//   ADDR_W        : note memory address width
//   COUNT_W       : width of a stored-note count (0..MEM_DEPTH)
//   KEY_*         : bit positions of the keys in the edge-detector vector
package music_pkg;

  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned COUNT_W   = $clog2(MEM_DEPTH + 1);

  localparam int unsigned KEY_RECORD = 0;
  localparam int unsigned KEY_PLAY   = 1;
  localparam int unsigned KEY_STOP   = 2;
  localparam int unsigned KEY_CLEAR  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRecWr,
    StRecGap,
    StClr,
    StPlayAddr,
    StPlayWait,
    StPlayShow,
    StPlayHold
  } ctrl_state_t;

  function automatic logic is_play_state(input ctrl_state_t s);
    return s inside {StPlayAddr, StPlayWait, StPlayShow, StPlayHold};
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a vector of level inputs.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   key_i  : level inputs (already debounced)
//   rise_o : one-cycle pulse per bit on a 0->1 transition
module key_edge_detect #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] key_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= key_i;
    end
  end

  assign rise_o = key_i & ~prev_q;

endmodule

// File: rtl/playback_controller.sv
// Control FSM for the note datapath: records notes, plays them back at a fixed
// tempo and sequences the VGA clear.
// Optional feature: define PLAYBACK_LOOP_EN to repeat the song until stop/clear.
//   clk, reset      : clock, asynchronous active-high reset
//   key_*           : level keys, acted on at rising edges (clear > stop > play > record)
//   dp_reset_n      : one-cycle low pulse rewinding the datapath write address
//   ld_note         : one-cycle write request
//   ld_play/playing : high in every play state
//   note_counter    : playback read address
//   display_note    : one-cycle draw strobe once read data is valid
//   clear           : VGA clear request, CLEAR_CYCLES long
//   note_count      : stored notes 0..16, rec_full when 16
module playback_controller
  import music_pkg::*;
#(
  parameter int unsigned NOTE_TICKS   = 25000000,
  parameter int unsigned CLEAR_CYCLES = 19200,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_record,
  input  logic               key_play,
  input  logic               key_stop,
  input  logic               key_clear,
  output logic               dp_reset_n,
  output logic               ld_note,
  output logic               ld_play,
  output logic [ADDR_W-1:0]  note_counter,
  output logic               display_note,
  output logic               clear,
  output logic [COUNT_W-1:0] note_count,
  output logic               rec_full,
  output logic               playing
);

  localparam int unsigned      TickW       = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [TickW-1:0] TickLast    = TickW'(NOTE_TICKS - 1);
  localparam logic [TickW-1:0] TickWaitEnd = TickW'(RD_LAT);
  localparam int unsigned      ClrW        = $clog2(CLEAR_CYCLES + 1);
  localparam logic [ClrW-1:0]  ClrLast     = ClrW'(CLEAR_CYCLES - 1);

  ctrl_state_t        state_q, state_d, after_note;
  logic [ADDR_W-1:0]  note_counter_q, note_counter_d;
  logic [COUNT_W-1:0] note_count_q, note_count_d;
  logic [COUNT_W-1:0] step_q, step_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [ClrW-1:0]    clr_q, clr_d;

  logic [3:0] key_rise;
  logic       rec_e, play_e, stop_e, clr_e;
  logic       full, note_done, song_end;

  key_edge_detect #(
    .Width(4)
  ) u_key_edge (
    .clk_i (clk),
    .rst_i (reset),
    .key_i ({key_clear, key_stop, key_play, key_record}),
    .rise_o(key_rise)
  );

  assign rec_e  = key_rise[KEY_RECORD];
  assign play_e = key_rise[KEY_PLAY];
  assign stop_e = key_rise[KEY_STOP];
  assign clr_e  = key_rise[KEY_CLEAR];

  assign full      = (note_count_q == COUNT_W'(MEM_DEPTH));
  // tick_q counts from 0 in PLAY_ADDR, so the note spans exactly NOTE_TICKS cycles.
  assign note_done = (tick_q == TickLast);
  assign song_end  = (step_q >= note_count_q);

  always_comb begin
`ifdef PLAYBACK_LOOP_EN
    after_note = StPlayAddr;
`else
    after_note = song_end ? StIdle : StPlayAddr;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr_e && state_q != StClr) begin
      state_d = StClr;
    end else if (stop_e && state_q != StClr) begin
      // In idle a stop edge simply swallows any lower-priority edge.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (play_e) begin
            if (note_count_q != '0) state_d = StPlayAddr;
          end else if (rec_e && !full) begin
            state_d = StRecWr;
          end
        end
        StRecWr:    state_d = StRecGap;
        StRecGap:   state_d = StIdle;
        StClr:      if (clr_q == ClrLast) state_d = StIdle;
        StPlayAddr: state_d = StPlayWait;
        StPlayWait: if (tick_q == TickWaitEnd) state_d = StPlayShow;
        // Only reachable with note_done when NOTE_TICKS is at its minimum.
        StPlayShow: state_d = note_done ? after_note : StPlayHold;
        StPlayHold: if (note_done) state_d = after_note;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Datapath registers: addresses, counts and timers
  always_comb begin
    note_counter_d = note_counter_q;
    note_count_d   = note_count_q;
    step_d         = step_q;
    tick_d         = tick_q + 1'b1;
    clr_d          = clr_q + 1'b1;

    // A write already issued counts even if stop arrives in the same cycle.
    if (state_q == StRecWr && !full) note_count_d = note_count_q + 1'b1;

    if (state_q == StPlayAddr) begin
      note_counter_d = note_counter_q + 1'b1;
      step_d         = step_q + 1'b1;
    end

    if (state_d == StPlayAddr) begin
      tick_d = '0;
      // Fresh start or loop restart: first address read is then 1.
      if (state_q == StIdle || song_end) begin
        note_counter_d = '0;
        step_d         = '0;
      end
    end

    if (state_d == StClr && state_q != StClr) begin
      note_count_d = '0;
      clr_d        = '0;
    end

    if (!is_play_state(state_d)) begin
      note_counter_d = '0;
      step_d         = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_counter_q <= '0;
      note_count_q   <= '0;
      step_q         <= '0;
      tick_q         <= '0;
      clr_q          <= '0;
    end else begin
      note_counter_q <= note_counter_d;
      note_count_q   <= note_count_d;
      step_q         <= step_d;
      tick_q         <= tick_d;
      clr_q          <= clr_d;
    end
  end

  // Outputs
  always_comb begin
    ld_note      = (state_q == StRecWr);
    dp_reset_n   = !(state_q == StClr && clr_q == '0);
    clear        = (state_q == StClr);
    playing      = is_play_state(state_q);
    ld_play      = playing;
    display_note = (state_q == StPlayShow);
    note_counter = note_counter_q;
    note_count   = note_count_q;
    rec_full     = full;
  end

endmodule

// File: doc/playback_controller.md
Name: playback_controller

Overview:
- Control FSM that sequences the note datapath: records notes into the 16-entry note memory, plays them back at a fixed tempo, and drives VGA clear and display strobes.
- Sits between the debounced key/switch inputs and the datapath load/play/display/clear controls.
- Tracks the stored-note count so playback covers exactly the recorded notes.

Parameters:
- NOTE_TICKS, 25000000, clk cycles each note is held during playback (0.5 s at 50 MHz); minimum 4.
- CLEAR_CYCLES, 19200, cycles the clear strobe is held while the VGA block wipes the screen.
- RD_LAT, 2, cycles from a note_counter change to valid memory read data.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_record  in  1  level; rising edge requests storing the current note
- key_play  in  1  level; rising edge starts playback
- key_stop  in  1  level; rising edge aborts record or playback
- key_clear  in  1  level; rising edge erases the song and screen
- dp_reset_n  out  1  active-low one-cycle pulse that rewinds the datapath write address
- ld_note  out  1  one-cycle write request to the datapath
- ld_play  out  1  high while playing; selects the read address
- note_counter  out  4  playback read address
- display_note  out  1  one-cycle strobe to draw the current note
- clear  out  1  VGA clear request
- note_count  out  5  stored notes, 0..16
- rec_full  out  1  note_count == 16
- playing  out  1  FSM in a PLAY_* state

Behaviour:
- Rising edges on all key_* inputs are detected internally with registered previous values.
- Priority when several edges occur in one cycle: clear > stop > play > record.
- Reset values:
  - outputs: dp_reset_n=1; ld_note, ld_play, display_note, clear, playing, rec_full = 0; note_counter=0; note_count=0.
  - state: IDLE.
- States and transitions:
  - IDLE:
    - record edge, not full -> REC_WR.
    - record edge while full -> ignored.
    - play edge, count>0 -> PLAY_ADDR.
    - play edge, count==0 -> ignored.
    - clear edge -> CLR.
  - REC_WR:
    - ld_note=1 for exactly one cycle; note_count+1 -> REC_GAP.
  - REC_GAP:
    - ld_note=0 for one cycle, so the datapath write enable drops -> IDLE.
    - Minimum record-to-record spacing: 3 cycles.
  - CLR:
    - dp_reset_n=0 in the first cycle only; clear=1 for CLEAR_CYCLES cycles; note_count<=0 on entry -> IDLE.
  - PLAY_ADDR:
    - ld_play=1; note_counter<=(note_counter+1) mod 16. Playback starts from a counter of 0, so the first address is 1, matching the datapath pre-increment write order 1..15,0.
    - Step index i increments -> PLAY_WAIT.
  - PLAY_WAIT:
    - Hold RD_LAT cycles -> PLAY_SHOW.
  - PLAY_SHOW:
    - display_note=1 for one cycle -> PLAY_HOLD.
  - PLAY_HOLD:
    - Tick counter runs so the total from PLAY_ADDR entry is NOTE_TICKS cycles.
    - At expiry: i<note_count -> PLAY_ADDR; else end-of-song (see feature).
  - ld_play and playing stay high through all PLAY_* states.
- Stop edge in any REC_*/PLAY_* state -> IDLE next cycle; ld_play, display_note, playing = 0; note_counter<=0. A REC_WR already issued still counts.
- Clear edge during playback -> CLR; playback aborted.
- Count saturates at 16; the 16th note lands at address 0. Further record edges are ignored.
- Tick counter width is $clog2(NOTE_TICKS); it resets to 0 on every PLAY_ADDR entry.
- Asynchronous reset mid-operation returns everything to reset values immediately; song count is lost.

Optional Feature:
- Macro: PLAYBACK_LOOP_EN.
- Defined: at end-of-song, note_counter<=0 and i<=0 -> PLAY_ADDR; the song repeats until stop or clear.
- Undefined: at end-of-song -> IDLE, ld_play=0, note_counter=0.

Decomposition:
- Package music_pkg holds:
  - state enum ctrl_state_t (IDLE, REC_WR, REC_GAP, CLR, PLAY_ADDR, PLAY_WAIT, PLAY_SHOW, PLAY_HOLD);
  - constants MEM_DEPTH=16, ADDR_W=4.
- One sub-module, key_edge_detect: a 4-bit rising-edge detector, instantiated once for all keys.

Test Plan:
- Reset, then 3 record edges spaced 5 cycles -> three 1-cycle ld_note pulses each followed by a low cycle; note_count=3.
- 3 notes, play edge, NOTE_TICKS=8 (not looped):
  - note_counter = 1,2,3, one value per 8 cycles;
  - display_note exactly RD_LAT=2 cycles after each change;
  - then IDLE, ld_play=0.
- 17 record edges -> note_count=16, rec_full=1, 17th ignored (no ld_note); play visits 1..15,0.
- Play, then stop edge mid-PLAY_HOLD of note 2 -> next cycle ld_play=0, note_counter=0, no further display_note.
- Clear edge with count=5 -> dp_reset_n low 1 cycle; clear high CLEAR_CYCLES; note_count=0; a play edge afterwards is ignored.
- PLAYBACK_LOOP_EN, 2 notes -> note_counter sequence 1,2,1,2,... until stop; reset asserted mid-note -> all outputs at reset values immediately.
